// File: rtl/reg_dump_reader.sv
// Walks an inclusive register-file index range through a dedicated read port
// and streams each captured value out over a valid/ready handshake.
module reg_dump_reader #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_index,
  output logic          m_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cur_reg, cur_next;
  logic [AW-1:0] last_q_reg, last_q_next;
  logic [DW-1:0] m_data_reg, m_data_next;
  logic [AW-1:0] m_index_reg, m_index_next;
  logic          m_last_reg, m_last_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      last_q_reg  <= '0;
      m_data_reg  <= '0;
      m_index_reg <= '0;
      m_last_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      last_q_reg  <= last_q_next;
      m_data_reg  <= m_data_next;
      m_index_reg <= m_index_next;
      m_last_reg  <= m_last_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    last_q_next  = last_q_reg;
    m_data_next  = m_data_reg;
    m_index_next = m_index_reg;
    m_last_next  = m_last_reg;
    rf_addr      = '0;
    m_valid      = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cur_next    = first_addr;
          last_q_next = last_addr;
          // An inverted range produces no beats but still reports completion.
          state_next  = (first_addr <= last_addr) ? READ : FIN;
        end
      end
      READ: begin
        rf_addr      = cur_reg;
        m_data_next  = rf_data;
        m_index_next = cur_reg;
        m_last_next  = (cur_reg == last_q_reg);
        state_next   = SEND;
      end
      SEND: begin
        rf_addr = cur_reg;
        m_valid = 1'b1;
        if (m_ready) begin
          // Ending on equality keeps cur from wrapping when last_addr is the top index.
          if (m_last_reg) begin
            state_next = FIN;
          end else begin
            cur_next   = cur_reg + 1'b1;
            state_next = READ;
          end
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign m_data  = m_data_reg;
  assign m_index = m_index_reg;
  assign m_last  = m_last_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: directed scenarios plus randomized
// ranges, stalls and register churn, compared against a queue-based beat model.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr;
  logic [4:0]  last_addr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_index;
  logic        m_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rf_data = rf[rf_addr];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  reg_dump_reader #(.DW(32), .AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, " busy"},    {31'd0, busy},    32'd0);
    chk({tag, " done"},    {31'd0, done},    32'd0);
    chk({tag, " rf_addr"}, {27'd0, rf_addr}, 32'd0);
    chk({tag, " m_data"},  m_data,           32'd0);
    chk({tag, " m_index"}, {27'd0, m_index}, 32'd0);
    chk({tag, " m_last"},  {31'd0, m_last},  32'd0);
  endtask

  // Runs one dump and checks every cycle against the expected beat queue.
  task automatic run_dump(input int first, input int last, input int stall_min,
                          input int stall_max, input bit churn, input int intrude_cycle);
    int  k, c, hs, stall_left;
    bit  new_beat, prev_stall, done_seen;
    exp_q.delete();
    if (first <= last)
      for (int i = first; i <= last; i++)
        exp_q.push_back('{idx: 5'(i), data: rf[i], last: (i == last)});
    k = exp_q.size();

    start      = 1'b1;
    first_addr = 5'(first);
    last_addr  = 5'(last);
    m_ready    = 1'b1;
    tick();
    start = 1'b0;

    c = 1; hs = 0; stall_left = 0;
    new_beat = 1'b1; prev_stall = 1'b0; done_seen = 1'b0;
    while (!done_seen && c < 400) begin
      if (m_valid) begin
        if (new_beat) begin
          stall_left = $urandom_range(stall_max, stall_min);
          new_beat   = 1'b0;
        end
        m_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        m_ready = 1'b1;
      end

      if (prev_stall) chk("valid held while stalled", {31'd0, m_valid}, 32'd1);

      if (done) begin
        done_seen = 1'b1;
        chk("beats left at done", exp_q.size(), 32'd0);
        chk("handshakes",         hs, k);
        chk("busy at done",       {31'd0, busy},    32'd1);
        chk("valid at done",      {31'd0, m_valid}, 32'd0);
        chk("rf_addr at done",    {27'd0, rf_addr}, 32'd0);
        if (stall_max == 0) chk("done cycle", c, 2 * k + 1);
      end else begin
        chk("busy", {31'd0, busy}, 32'd1);
        if (exp_q.size() > 0) begin
          chk("rf_addr", {27'd0, rf_addr}, {27'd0, exp_q[0].idx});
          if (m_valid) begin
            chk("m_index", {27'd0, m_index}, {27'd0, exp_q[0].idx});
            chk("m_data",  m_data,           exp_q[0].data);
            chk("m_last",  {31'd0, m_last},  {31'd0, exp_q[0].last});
            if (m_ready) begin
              void'(exp_q.pop_front());
              hs++;
              new_beat = 1'b1;
            end else if (churn && exp_q[0].idx != 5'd0) begin
              rf[exp_q[0].idx] = $urandom;
            end
          end
        end else begin
          chk("extra beat", {31'd0, m_valid}, 32'd0);
        end
      end
      prev_stall = m_valid && !m_ready;

      if (c == intrude_cycle) begin
        start = 1'b1; first_addr = 5'd0; last_addr = 5'd1;
      end
      if (!done_seen) begin
        tick();
        start = 1'b0;
        c++;
      end
    end
    if (!done_seen) chk("timeout waiting for done", 32'd0, 32'd1);
    m_ready = 1'b1;
    tick();
    chk("busy after done",  {31'd0, busy},    32'd0);
    chk("single done",      {31'd0, done},    32'd0);
    chk("valid after done", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    int a, b, n;
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; m_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
    tick(); tick();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Full dump with ready tied high.
    run_dump(0, 31, 0, 0, 1'b0, -1);
    // Backpressure: exactly three stalled cycles on every beat.
    run_dump(4, 6, 3, 3, 1'b0, -1);
    // Single-register and empty ranges.
    run_dump(9, 9, 0, 0, 1'b0, -1);
    run_dump(10, 9, 0, 0, 1'b0, -1);
    // start during a dump must be ignored.
    run_dump(20, 22, 0, 0, 1'b0, 2);

    // Reset while index 7 is being offered.
    start = 1'b1; first_addr = 5'd5; last_addr = 5'd12; m_ready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(m_valid && m_index == 5'd7) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("timeout waiting for index 7", 32'd0, 32'd1);
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_zero("mid-dump reset");
    m_ready = 1'b1;
    tick();
    chk("no done after reset", {31'd0, done}, 32'd0);
    chk("idle after reset",    {31'd0, busy}, 32'd0);
    run_dump(5, 12, 0, 0, 1'b0, -1);

    // Randomized contents, ranges and stalls, with writes to captured indices.
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    for (int t = 0; t < 25; t++) begin
      a = $urandom_range(31, 0);
      b = $urandom_range(31, 0);
      if (t % 5 == 4) run_dump(31, 31, 0, 2, 1'b1, -1);
      else            run_dump(a, b, 0, $urandom_range(2, 0), 1'b1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
